// File: rtl/ti_sbox_pkg.sv
// Shared constants and types for the sequential threshold-implementation S-box wrapper.
package ti_sbox_pkg;

    localparam int unsigned SHARE_W  = 8;
    localparam int unsigned NSHARES  = 3;
    localparam int unsigned NRND     = 2;
    localparam int unsigned SHARES_W = NSHARES * SHARE_W;
    localparam int unsigned RND_W    = NRND * SHARE_W;
    localparam int unsigned SEL_W    = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        REFR = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/ti_mask_refresh.sv
// Re-masks a three-share value with two fresh random words; the XOR of the shares is preserved.
module ti_mask_refresh #(
    parameter int unsigned SHARE_W = ti_sbox_pkg::SHARE_W
) (
    input  logic [ti_sbox_pkg::NSHARES*SHARE_W-1:0] data_in,
    input  logic [ti_sbox_pkg::NRND*SHARE_W-1:0]    rnd,
    output logic [ti_sbox_pkg::NSHARES*SHARE_W-1:0] data_out
);
    import ti_sbox_pkg::*;

    logic [SHARE_W-1:0] r0;
    logic [SHARE_W-1:0] r1;

    assign r0 = rnd[SHARE_W-1:0];
    assign r1 = rnd[NRND*SHARE_W-1:SHARE_W];

    // share0 ^= r0, share1 ^= r1, share2 ^= r0 ^ r1
    always_comb begin
        data_out                          = data_in;
        data_out[SHARE_W-1:0]             = data_in[SHARE_W-1:0] ^ r0;
        data_out[2*SHARE_W-1:SHARE_W]     = data_in[2*SHARE_W-1:SHARE_W] ^ r1;
        data_out[3*SHARE_W-1:2*SHARE_W]   = data_in[3*SHARE_W-1:2*SHARE_W] ^ r0 ^ r1;
    end

endmodule

// File: rtl/ti_sbox_seq.sv
// Sequencer for a masked S-box: drives an external share-function array round by round,
// re-masking the shares between rounds with fresh randomness.
module ti_sbox_seq #(
    parameter int unsigned NROUNDS = 3,
    parameter int unsigned REFRESH = 1,
    parameter int unsigned SHARE_W = ti_sbox_pkg::SHARE_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [3*SHARE_W-1:0]   in_shares,
    output logic [1:0]             fn_sel,
    output logic [3*SHARE_W-1:0]   fn_in,
    input  logic [3*SHARE_W-1:0]   fn_out,
    output logic                   rnd_req,
    input  logic                   rnd_valid,
    input  logic [2*SHARE_W-1:0]   rnd,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [3*SHARE_W-1:0]   out_shares,
    output logic                   busy
);
    import ti_sbox_pkg::*;

    localparam int unsigned DW       = NSHARES * SHARE_W;
    localparam logic [1:0]  LAST_RND = 2'(NROUNDS - 1);

    state_t          state_q;
    state_t          state_d;
    logic [1:0]      rnd_q;
    logic [1:0]      rnd_d;
    logic [DW-1:0]   data_q;
    logic [DW-1:0]   data_d;
    logic [DW-1:0]   refr_data;

    ti_mask_refresh #(
        .SHARE_W (SHARE_W)
    ) u_refresh (
        .data_in  (data_q),
        .rnd      (rnd),
        .data_out (refr_data)
    );

    // State, round counter and share register; reset wins over any handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rnd_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            data_q  <= data_d;
        end
    end

    // Next-state and outputs; share-carrying outputs are forced to zero outside their own state.
    always_comb begin
        state_d    = state_q;
        rnd_d      = rnd_q;
        data_d     = data_q;
        in_ready   = 1'b0;
        busy       = 1'b1;
        fn_sel     = '0;
        fn_in      = '0;
        rnd_req    = 1'b0;
        out_valid  = 1'b0;
        out_shares = '0;
        case (state_q)
            IDLE: begin
                busy     = 1'b0;
                in_ready = 1'b1;
                if (in_valid) begin
                    data_d  = in_shares;
                    rnd_d   = '0;
                    state_d = EVAL;
                end
            end
            EVAL: begin
                fn_in  = data_q;
                fn_sel = rnd_q;
                data_d = fn_out;
                if (rnd_q == LAST_RND) begin
                    state_d = DONE;
                end else if (REFRESH != 0) begin
                    state_d = REFR;
                end else begin
                    rnd_d = rnd_q + 2'd1;
                end
            end
            REFR: begin
                rnd_req = 1'b1;
                if (rnd_valid) begin
                    data_d  = refr_data;
                    rnd_d   = rnd_q + 2'd1;
                    state_d = EVAL;
                end
            end
            DONE: begin
                out_valid  = 1'b1;
                out_shares = data_q;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ti_sbox_seq.sv
// Scoreboard bench for ti_sbox_seq: one instance with re-masking, one without.
module tb_ti_sbox_seq;

    typedef struct {
        logic [23:0] sh;
        int unsigned acc;
        int unsigned lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [23:0] in_shares = '0;
    logic [1:0]  fn_sel;
    logic [23:0] fn_in;
    logic [23:0] fn_out;
    logic        rnd_req;
    logic        rnd_valid = 1'b1;
    logic [15:0] rnd = 16'hA55A;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [23:0] out_shares;
    logic        busy;

    logic        iv_n = 1'b0;
    logic        ir_n;
    logic [23:0] ish_n = '0;
    logic [1:0]  fsel_n;
    logic [23:0] fin_n;
    logic [23:0] fout_n;
    logic        rreq_n;
    logic        ov_n;
    logic        ordy_n = 1'b1;
    logic [23:0] osh_n;
    logic        busy_n;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned cyc = 0;
    exp_t        q[$];
    exp_t        qn[$];
    exp_t        cur;
    exp_t        cur_n;
    bit          ov_prev = 1'b0;
    bit          ovn_prev = 1'b0;
    bit          nr_rnd_seen = 1'b0;

    assign fn_out = fn_in ^ 24'h010101;
    assign fout_n = fin_n ^ 24'h010101;

    ti_sbox_seq #(.NROUNDS(3), .REFRESH(1), .SHARE_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_shares(in_shares),
        .fn_sel(fn_sel), .fn_in(fn_in), .fn_out(fn_out), .rnd_req(rnd_req), .rnd_valid(rnd_valid),
        .rnd(rnd), .out_valid(out_valid), .out_ready(out_ready), .out_shares(out_shares), .busy(busy)
    );

    ti_sbox_seq #(.NROUNDS(3), .REFRESH(0), .SHARE_W(8)) dut_nr (
        .clk(clk), .rst(rst), .in_valid(iv_n), .in_ready(ir_n), .in_shares(ish_n),
        .fn_sel(fsel_n), .fn_in(fin_n), .fn_out(fout_n), .rnd_req(rreq_n), .rnd_valid(rnd_valid),
        .rnd(rnd), .out_valid(ov_n), .out_ready(ordy_n), .out_shares(osh_n), .busy(busy_n)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h want=%h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Monitor for the re-masking instance: first out_valid cycle pops the scoreboard, later cycles check hold.
    always @(negedge clk) begin
        if (rst) begin
            ov_prev = 1'b0;
        end else if (out_valid) begin
            if (!ov_prev) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL out_unexpected got=%h want=none (cycle %0d)", out_shares, cyc);
                end else begin
                    cur = q.pop_front();
                    chk("out_shares", {8'h0, out_shares}, {8'h0, cur.sh});
                    chk("out_latency", cyc - cur.acc, cur.lat);
                end
            end else begin
                chk("out_hold", {8'h0, out_shares}, {8'h0, cur.sh});
            end
            ov_prev = !out_ready;
        end else begin
            ov_prev = 1'b0;
        end
    end

    // Monitor for the no-refresh instance.
    always @(negedge clk) begin
        if (rreq_n) nr_rnd_seen = 1'b1;
        if (rst) begin
            ovn_prev = 1'b0;
        end else if (ov_n) begin
            if (!ovn_prev) begin
                if (qn.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL nr_out_unexpected got=%h want=none (cycle %0d)", osh_n, cyc);
                end else begin
                    cur_n = qn.pop_front();
                    chk("nr_out_shares", {8'h0, osh_n}, {8'h0, cur_n.sh});
                    chk("nr_out_latency", cyc - cur_n.acc, cur_n.lat);
                end
            end else begin
                chk("nr_out_hold", {8'h0, osh_n}, {8'h0, cur_n.sh});
            end
            ovn_prev = !ordy_n;
        end else begin
            ovn_prev = 1'b0;
        end
    end

    // Offer a triple at a falling edge; returns one cycle after acceptance.
    task automatic send(input bit which, input logic [23:0] sh, input logic [23:0] exp,
                        input int unsigned lat, input bit push, output int unsigned acc);
        int unsigned n = 0;
        if (which == 1'b0) begin in_shares = sh; in_valid = 1'b1; end
        else begin ish_n = sh; iv_n = 1'b1; end
        while (((which == 1'b0) ? !in_ready : !ir_n) && n < 50) begin
            @(negedge clk);
            n++;
        end
        acc = cyc;
        chk("accept_timeout", {31'h0, n < 50}, 32'h1);
        if (push && n < 50) begin
            if (which == 1'b0) q.push_back('{exp, acc, lat});
            else qn.push_back('{exp, acc, lat});
        end
        @(negedge clk);
        in_valid = 1'b0;
        iv_n     = 1'b0;
        in_shares = '0;
        ish_n    = '0;
    endtask

    task automatic drain(input bit which);
        int unsigned n = 0;
        while ((which == 1'b0 ? (q.size() != 0 || out_valid) : (qn.size() != 0 || ov_n)) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", {31'h0, n < 100}, 32'h1);
    endtask

    initial begin
        int unsigned a1;
        int unsigned a2;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_flags", {26'h0, in_ready, busy, out_valid, rnd_req, fn_sel}, {26'h0, 6'b100000});
        chk("reset_fn_in", {8'h0, fn_in}, 32'h0);
        chk("reset_out_shares", {8'h0, out_shares}, 32'h0);

        // Zero input: XOR of result shares must come out as 01, first refresh visible in round 2 operand.
        send(1'b0, 24'h000000, 24'h010101, 6, 1'b1, a1);
        chk("v1_c1_fn_sel", {30'h0, fn_sel}, 32'h0);
        chk("v1_c1_busy", {31'h0, busy}, 32'h1);
        @(negedge clk);
        chk("v1_c2_rnd_req", {31'h0, rnd_req}, 32'h1);
        chk("v1_c2_fn_in", {8'h0, fn_in}, 32'h0);
        @(negedge clk);
        chk("v1_c3_fn_in_refreshed", {8'h0, fn_in}, {8'h0, 24'hFEA45B});
        chk("v1_c3_fn_sel", {30'h0, fn_sel}, 32'h1);
        drain(1'b0);

        // Consumer stalls 4 cycles; a second offer during DONE and during the handshake is refused.
        out_ready = 1'b0;
        send(1'b0, 24'h332211, 24'h322310, 6, 1'b1, a1);
        @(negedge clk);
        @(negedge clk);
        chk("v2_c3_fn_in_refreshed", {8'h0, fn_in}, {8'h0, 24'hCD864A});
        repeat (3) @(negedge clk);
        in_valid  = 1'b1;
        in_shares = 24'hABCDEF;
        for (int i = 0; i < 4; i++) begin
            chk("v2_in_ready_done", {31'h0, in_ready}, 32'h0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        chk("v2_in_ready_hs", {31'h0, in_ready}, 32'h0);
        @(negedge clk);
        chk("v2_idle_after_hs", {30'h0, in_ready, busy}, 32'h2);
        in_valid  = 1'b0;
        in_shares = '0;
        @(negedge clk);
        chk("v2_not_accepted", {31'h0, busy}, 32'h0);

        // Randomness withheld for 5 cycles in the first REFR.
        rnd_valid = 1'b0;
        send(1'b0, 24'hC35A0F, 24'hC25B0E, 11, 1'b1, a1);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("v3_wait_rnd_req", {31'h0, rnd_req}, 32'h1);
            chk("v3_wait_fn_in", {8'h0, fn_in}, 32'h0);
            chk("v3_wait_fn_sel", {30'h0, fn_sel}, 32'h0);
            @(negedge clk);
        end
        rnd_valid = 1'b1;
        @(negedge clk);
        chk("v3_rnd_req_drop", {31'h0, rnd_req}, 32'h0);
        chk("v3_fn_sel_after", {30'h0, fn_sel}, 32'h1);
        drain(1'b0);

        // Reset in the second EVAL aborts the triple.
        send(1'b0, 24'h123456, 24'h0, 0, 1'b0, a1);
        @(negedge clk);
        @(negedge clk);
        chk("v4_in_eval2", {30'h0, fn_sel}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("v4_after_rst", {29'h0, in_ready, busy, out_valid}, 32'h4);
        chk("v4_after_rst_fn", {8'h0, fn_in}, 32'h0);
        repeat (10) @(negedge clk);

        // Reset and an input offer in the same cycle: reset wins.
        in_valid  = 1'b1;
        in_shares = 24'h777777;
        rst       = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_shares = '0;
        chk("v4_rst_priority", {30'h0, in_ready, busy}, 32'h2);

        // Back-to-back triples: minimum spacing 2*NROUNDS+1.
        send(1'b0, 24'hA1B2C3, 24'hA0B3C2, 6, 1'b1, a1);
        send(1'b0, 24'h0F0F0F, 24'h0E0E0E, 6, 1'b1, a2);
        chk("v5_issue_spacing", a2 - a1, 32'd7);
        drain(1'b0);

        // No re-masking: three consecutive EVAL cycles, result at cycle 4.
        send(1'b1, 24'h000000, 24'h010101, 4, 1'b1, a1);
        chk("v6_c1_fn_sel", {30'h0, fsel_n}, 32'h0);
        @(negedge clk);
        chk("v6_c2_fn_sel", {30'h0, fsel_n}, 32'h1);
        chk("v6_c2_fn_in", {8'h0, fin_n}, {8'h0, 24'h010101});
        @(negedge clk);
        chk("v6_c3_fn_sel", {30'h0, fsel_n}, 32'h2);
        chk("v6_c3_fn_in", {8'h0, fin_n}, 32'h0);
        drain(1'b1);
        chk("v6_rnd_req_never", {31'h0, nr_rnd_seen}, 32'h0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ti_sbox_seq.md
TI_SBOX_SEQ -- requirements
Module: ti_sbox_seq

Interface
REQ-001 Parameter NROUNDS, default 3: quadratic rounds per S-box evaluation; legal range 1..4.
REQ-002 Parameter REFRESH, default 1: 1 = re-mask shares between rounds; 0 = no re-masking.
REQ-003 Parameter SHARE_W, default 8: bits per share; the share count is fixed at 3.
REQ-004 clk  in  1  single clock; all logic on the rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 in_valid  in  1  input share triple offered.
REQ-007 in_ready  out  1  block accepts a triple.
REQ-008 in_shares  in  3*SHARE_W  share0 in [7:0], share1 in [15:8], share2 in [23:16].
REQ-009 fn_sel  out  2  round index driven to the external share-function array.
REQ-010 fn_in  out  3*SHARE_W  operand to the external combinational share-function array.
REQ-011 fn_out  in  3*SHARE_W  result from the array, valid in the same cycle.
REQ-012 rnd_req  out  1  fresh randomness requested.
REQ-013 rnd_valid  in  1  rnd is valid this cycle.
REQ-014 rnd  in  2*SHARE_W  fresh mask bits: r0 in [7:0], r1 in [15:8].
REQ-015 out_valid  out  1  result triple available.
REQ-016 out_ready  in  1  consumer takes the result.
REQ-017 out_shares  out  3*SHARE_W  result shares, same packing as in_shares.
REQ-018 busy  out  1  high in any state other than IDLE.

Function
REQ-019 The FSM SHALL have four states: IDLE, EVAL, REFR and DONE; a round counter rnd_q and a share register data_q.
REQ-020 IDLE: in_ready=1; on in_valid, data_q<=in_shares, rnd_q<=0, next state EVAL.
REQ-021 EVAL: fn_in=data_q and fn_sel=rnd_q, taking exactly one cycle; data_q<=fn_out.
REQ-022 Leaving EVAL: if rnd_q==NROUNDS-1, go to DONE; else go to REFR when REFRESH=1.
REQ-023 Leaving EVAL with REFRESH=0 and rnd_q<NROUNDS-1: rnd_q++ and stay in EVAL.
REQ-024 REFR: rnd_req=1 and wait; on rnd_valid, data_q<=refresh(data_q,rnd), rnd_q++, next state EVAL.
REQ-025 refresh(): share0^=r0, share1^=r1, share2^=r0^r1, so the XOR of the three shares is unchanged.
REQ-026 DONE: out_valid=1 and out_shares=data_q; on out_ready, go to IDLE.
REQ-027 Outputs SHALL hold stable while out_valid=1 and out_ready=0.
REQ-028 fn_in SHALL be all-zero outside EVAL; out_shares SHALL be all-zero outside DONE (leakage hygiene).
REQ-029 in_ready=0 in EVAL, REFR and DONE; no acceptance in the same cycle as an out_ready handshake.
REQ-030 rnd_valid SHALL be ignored outside REFR.
REQ-031 With rnd_valid held high and NROUNDS=3, REFRESH=1: accept in cycle 0, EVAL in cycles 1/3/5, REFR in cycles 2/4, out_valid first in cycle 6.
REQ-032 Back-to-back issue rate SHALL be one triple per 2*NROUNDS+1 cycles minimum (REFRESH=1).
REQ-033 rnd_req deasserts in the cycle after the rnd_valid handshake.
REQ-034 fn_sel SHALL be 0 outside EVAL.

Reset
REQ-035 On rst: state<=IDLE, rnd_q<=0, data_q<=0.
REQ-036 After rst: in_ready=1 and all other outputs 0, including busy.
REQ-037 rst asserted in any state SHALL abort the evaluation, with no out_valid for the aborted triple.
REQ-038 rst has priority over every handshake in the same cycle.

Structure
REQ-039 Package ti_sbox_pkg SHALL hold SHARE_W, the NSHARES=3 constant, the state enum and the share-packing widths.
REQ-040 One combinational sub-module, ti_mask_refresh, SHALL implement refresh(); everything else is flat in ti_sbox_seq.
REQ-041 The share-function array SHALL stay external; this block holds no S-box logic.

Verification
REQ-042 NROUNDS=3, REFRESH=1, rnd_valid tied high, fn_out=fn_in^{8'h01,8'h01,8'h01}, in_shares=24'h00_00_00 -> out_valid in cycle 6 and XOR of out_shares == 8'h01.
REQ-043 Same fn_out stub, rnd=16'hA55A -> data_q after the first REFR = {8'h01^8'h5A^8'hA5, 8'h01^8'hA5, 8'h01^8'h5A} in share2/share1/share0 order.
REQ-044 rnd_valid withheld 5 cycles in REFR -> rnd_req held, fn_in=0, rnd_q unchanged, and out_valid 5 cycles late.
REQ-045 out_ready low 4 cycles in DONE -> out_shares stable, in_ready=0, and a second in_valid is not accepted.
REQ-046 rst pulsed in the cycle of the second EVAL -> next cycle IDLE, in_ready=1, busy=0, and no out_valid for that triple.
REQ-047 REFRESH=0, NROUNDS=3 -> rnd_req never asserts and out_valid is first seen in cycle 4.
